// File: rtl/pipelined_shift_unit_if.sv
// Operand/result handshake bundle for the pipelined shift unit.
// master drives operands and out_ready; slave is the shifter.
interface pipelined_shift_unit_if #(
   parameter int WIDTH   = 16,
   parameter int SHIFT_W = 4,
   parameter int TAG_W   = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SHIFT_W-1:0] in_shift;
   logic [1:0]         in_mode;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_ovf;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, in_data, in_shift, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_shift, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_tag
   );
endinterface

// File: rtl/pipelined_shift_unit.sv
// Log-stage pipelined barrel shifter: stage k shifts by 2^k, the last stage
// applies saturation / rounding and doubles as the output register.
module pipelined_shift_unit #(
   parameter int WIDTH    = 16,
   parameter int SHIFT_W  = 4,
   parameter int TAG_W    = 4,
   parameter int SATURATE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipelined_shift_unit_if.slave bus
);
   // grd is the last bit shifted out (rounding), ovf accumulates left-shift overflow,
   // sgn is the operand's original sign for the saturation choice.
   typedef struct packed {
      logic               vld;
      logic [WIDTH-1:0]   data;
      logic [TAG_W-1:0]   tag;
      logic [1:0]         mode;
      logic [SHIFT_W-1:0] shift;
      logic               ovf;
      logic               grd;
      logic               sgn;
   } stage_t;

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   stage_t w_stg [SHIFT_W+1];
   logic   w_adv;

   assign w_adv        = !w_stg[SHIFT_W].vld || bus.out_ready;
   assign bus.in_ready = w_adv;

   assign w_stg[0] = '{vld:   bus.in_valid,
                       data:  bus.in_data,
                       tag:   bus.in_tag,
                       mode:  bus.in_mode,
                       shift: bus.in_shift,
                       ovf:   1'b0,
                       grd:   1'b0,
                       sgn:   bus.in_data[WIDTH-1]};

   for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
      localparam int N    = 2 ** k;
      localparam bit LAST = (k == SHIFT_W - 1);

      stage_t           r_stg;
      stage_t           w_nxt;
      logic [WIDTH-1:0] w_asr;
      logic [WIDTH-1:0] w_lsr;
      logic [WIDTH-1:0] w_lsl;
      logic             w_grd_sh;
      logic             w_ovf_sh;

      if (N < WIDTH) begin : g_near
         // Top N+1 bits must agree, otherwise the left shift changes the sign.
         localparam logic [WIDTH-1:0] TOP_M = ~({WIDTH{1'b1}} >> (N + 1));
         assign w_asr    = $signed(w_stg[k].data) >>> N;
         assign w_lsr    = w_stg[k].data >> N;
         assign w_lsl    = w_stg[k].data << N;
         assign w_grd_sh = w_stg[k].data[N-1];
         assign w_ovf_sh = ((w_stg[k].data & TOP_M) != '0) &&
                           ((w_stg[k].data & TOP_M) != TOP_M);
      end else begin : g_far
         assign w_asr    = {WIDTH{w_stg[k].data[WIDTH-1]}};
         assign w_lsr    = '0;
         assign w_lsl    = '0;
         assign w_grd_sh = w_stg[k].data[WIDTH-1];
         assign w_ovf_sh = (w_stg[k].data != '0);
      end

      // Next-state of this stage: conditional shift, then final-stage fix-up.
      always_comb begin
         w_nxt = w_stg[k];
         if (w_stg[k].shift[k]) begin
            w_nxt.grd = w_grd_sh;
            w_nxt.ovf = w_stg[k].ovf | w_ovf_sh;
            case (w_stg[k].mode)
               2'b01:   w_nxt.data = w_lsr;
               2'b10:   w_nxt.data = w_lsl;
               default: w_nxt.data = w_asr;
            endcase
         end else begin
            w_nxt.data = w_stg[k].data;
         end
         if (LAST) begin
            case (w_nxt.mode)
               2'b10: begin
                  if (w_nxt.ovf && (SATURATE != 0)) begin
                     w_nxt.data = w_nxt.sgn ? SAT_MIN : SAT_MAX;
                  end else begin
                     w_nxt.data = w_nxt.data;
                  end
               end
               2'b11: begin
                  w_nxt.data = w_nxt.data + {{(WIDTH-1){1'b0}}, w_nxt.grd};
                  w_nxt.ovf  = 1'b0;
               end
               default: w_nxt.ovf = 1'b0;
            endcase
         end else begin
            w_nxt.ovf = w_nxt.ovf;
         end
      end

      // Stage register; the whole pipeline freezes when the output is stalled.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stg <= '0;
         end else if (w_adv) begin
            r_stg <= w_nxt;
         end else begin
            r_stg <= r_stg;
         end
      end

      assign w_stg[k+1] = r_stg;
   end

   assign bus.out_valid = w_stg[SHIFT_W].vld;
   assign bus.out_data  = w_stg[SHIFT_W].data;
   assign bus.out_ovf   = w_stg[SHIFT_W].ovf;
   assign bus.out_tag   = w_stg[SHIFT_W].tag;
endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Scoreboard bench for pipelined_shift_unit (WIDTH=16, SHIFT_W=4); a second
// instance with SATURATE=0 covers the wrapping left shift.
module tb_pipelined_shift_unit;
   localparam int WIDTH   = 16;
   localparam int SHIFT_W = 4;
   localparam int TAG_W   = 4;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             ovf;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t pend;
   bit   acc;
   int   tag_n;

   pipelined_shift_unit_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) bus ();
   pipelined_shift_unit_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)) bus_w ();

   pipelined_shift_unit #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W), .SATURATE(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   pipelined_shift_unit #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .bus(bus_w)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: [WIDTH] = ovf, [WIDTH-1:0] = result.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input int s,
                                            input logic [1:0] m, input bit sat);
      logic signed [WIDTH-1:0] sd;
      logic [WIDTH-1:0] r;
      logic o;
      logic rb;
      sd = d;
      o  = 1'b0;
      rb = 1'b0;
      r  = d;
      case (m)
         2'b00: r = (s >= WIDTH) ? {WIDTH{d[WIDTH-1]}} : WIDTH'(sd >>> s);
         2'b01: r = (s >= WIDTH) ? '0 : (d >> s);
         2'b10: begin
            if (s >= WIDTH) o = (d != '0);
            else for (int i = WIDTH - 1 - s; i < WIDTH - 1; i++) if (d[i] != d[WIDTH-1]) o = 1'b1;
            r = (s >= WIDTH) ? '0 : (d << s);
            if (o && sat) r = d[WIDTH-1] ? 16'h8000 : 16'h7FFF;
         end
         default: begin
            if (s == 0) rb = 1'b0;
            else if (s > WIDTH) rb = d[WIDTH-1];
            else rb = d[s-1];
            r = ((s >= WIDTH) ? {WIDTH{d[WIDTH-1]}} : WIDTH'(sd >>> s)) + WIDTH'(rb);
         end
      endcase
      return {o, r};
   endfunction

   task automatic drive(input logic [WIDTH-1:0] d, input int s, input logic [1:0] m,
                        input logic [WIDTH-1:0] exp_d, input logic exp_o);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shift = SHIFT_W'(s);
      bus.in_mode  = m;
      bus.in_tag   = TAG_W'(tag_n);
      pend.tag     = TAG_W'(tag_n);
      pend.data    = exp_d;
      pend.ovf     = exp_o;
   endtask

   // Settle, log accepted inputs and check produced outputs, then move to the next cycle.
   task automatic step();
      exp_t e;
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (acc) sb_q.push_back(pend);
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            check_value("spurious_out", 32'(bus.out_tag), 32'hFFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            check_value($sformatf("data_t%0d", e.tag), 32'(bus.out_data), 32'(e.data));
            check_value($sformatf("ovf_t%0d", e.tag),  32'(bus.out_ovf),  32'(e.ovf));
            check_value("tag_order", 32'(bus.out_tag), 32'(e.tag));
         end
      end
      @(negedge clk);
   endtask

   task automatic send_dir(input logic [WIDTH-1:0] d, input int s, input logic [1:0] m,
                           input logic [WIDTH-1:0] exp_d, input logic exp_o);
      drive(d, s, m, exp_d, exp_o);
      step();
      check_value("dir_accept", 32'(acc), 32'd1);
      tag_n++;
   endtask

   task automatic drain();
      int n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (sb_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check_value("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic measure_latency(input string name, input logic [WIDTH-1:0] d, input int s,
                                  input logic [1:0] m, input logic [WIDTH-1:0] exp_d);
      int lat;
      bus.out_ready = 1'b1;
      drive(d, s, m, exp_d, 1'b0);
      #1;
      check_value({name, "_rdy"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_value({name, "_lat"}, 32'(lat), 32'd4);
      check_value({name, "_data"}, 32'(bus.out_data), 32'(exp_d));
      @(negedge clk);
   endtask

   task automatic sat0_check(input string name, input logic [WIDTH-1:0] d, input int s,
                             input logic [WIDTH-1:0] exp_d, input logic exp_o);
      int n = 0;
      bus_w.out_ready = 1'b1;
      bus_w.in_valid  = 1'b1;
      bus_w.in_data   = d;
      bus_w.in_shift  = SHIFT_W'(s);
      bus_w.in_mode   = 2'b10;
      bus_w.in_tag    = 4'h3;
      @(negedge clk);
      bus_w.in_valid = 1'b0;
      while (!bus_w.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_value({name, "_vld"},  32'(bus_w.out_valid), 32'd1);
      check_value({name, "_data"}, 32'(bus_w.out_data),  32'(exp_d));
      check_value({name, "_ovf"},  32'(bus_w.out_ovf),   32'(exp_o));
      @(negedge clk);
   endtask

   initial begin
      logic [WIDTH-1:0] hold_d;
      logic [TAG_W-1:0] hold_t;
      logic [WIDTH:0]   mr;
      logic [WIDTH-1:0] d;
      int s, m, sent, cyc;
      bit stale;

      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shift = '0; bus.in_mode = 2'b00;
      bus.in_tag = '0; bus.out_ready = 1'b1;
      bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.in_shift = '0; bus_w.in_mode = 2'b00;
      bus_w.in_tag = '0; bus_w.out_ready = 1'b1;
      pend = '0;
      tag_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_value("rst_out_data",  32'(bus.out_data),  32'd0);
      check_value("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
      check_value("rst_out_tag",   32'(bus.out_tag),   32'd0);
      check_value("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(negedge clk);

      measure_latency("lat0", 16'hF000, 4, 2'b00, 16'hFF00);

      // Directed vectors, back to back at full throughput.
      bus.out_ready = 1'b1;
      send_dir(16'hF000,  4, 2'b00, 16'hFF00, 1'b0);
      send_dir(16'hF000,  4, 2'b01, 16'h0F00, 1'b0);
      send_dir(16'h8421,  0, 2'b00, 16'h8421, 1'b0);
      send_dir(16'h8421,  0, 2'b01, 16'h8421, 1'b0);
      send_dir(16'h8421,  0, 2'b10, 16'h8421, 1'b0);
      send_dir(16'h8421,  0, 2'b11, 16'h8421, 1'b0);
      send_dir(16'h0018,  4, 2'b11, 16'h0002, 1'b0);
      send_dir(16'hFFE8,  4, 2'b11, 16'hFFFF, 1'b0);
      send_dir(16'h0017,  4, 2'b11, 16'h0001, 1'b0);
      send_dir(16'h8000, 15, 2'b11, 16'hFFFF, 1'b0);
      send_dir(16'h0123,  3, 2'b10, 16'h0918, 1'b0);
      send_dir(16'h1234,  3, 2'b10, 16'h7FFF, 1'b1);
      send_dir(16'hF000,  3, 2'b10, 16'h8000, 1'b0);
      send_dir(16'hFFFF, 15, 2'b10, 16'h8000, 1'b0);
      send_dir(16'h0001, 15, 2'b10, 16'h7FFF, 1'b1);
      send_dir(16'h8000,  1, 2'b10, 16'h8000, 1'b1);
      send_dir(16'h8000, 15, 2'b00, 16'hFFFF, 1'b0);
      send_dir(16'h8000, 15, 2'b01, 16'h0001, 1'b0);
      drain();

      sat0_check("wrap_1234", 16'h1234,  3, 16'h91A0, 1'b1);
      sat0_check("wrap_0001", 16'h0001, 15, 16'h8000, 1'b1);

      // Backpressure: pipeline fills with four operands and then freezes.
      bus.out_ready = 1'b0;
      tag_n = 1;
      for (int c = 0; c < 10; c++) begin
         d  = 16'h0F0F ^ {4{4'(tag_n)}};
         mr = model(d, tag_n, 2'(tag_n), 1'b1);
         drive(d, tag_n, 2'(tag_n), mr[WIDTH-1:0], mr[WIDTH]);
         step();
         if (acc) tag_n++;
      end
      check_value("bp_accepted", 32'(tag_n - 1), 32'd4);
      check_value("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_value("bp_head_tag", 32'(bus.out_tag), 32'd1);
      hold_d = bus.out_data;
      hold_t = bus.out_tag;
      repeat (3) step();
      check_value("bp_hold_data", 32'(bus.out_data), 32'(hold_d));
      check_value("bp_hold_tag",  32'(bus.out_tag),  32'(hold_t));
      bus.out_ready = 1'b1;
      cyc = 0;
      while (tag_n <= 8 && cyc < 50) begin
         d  = 16'h0F0F ^ {4{4'(tag_n)}};
         mr = model(d, tag_n, 2'(tag_n), 1'b1);
         drive(d, tag_n, 2'(tag_n), mr[WIDTH-1:0], mr[WIDTH]);
         step();
         if (acc) tag_n++;
         cyc++;
      end
      check_value("bp_all_sent", 32'(tag_n), 32'd9);
      drain();

      // Random stream with random backpressure.
      sent = 0;
      cyc  = 0;
      while ((sent < 100 || sb_q.size() != 0) && cyc < 3000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (sent < 100 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 5))
               0:       d = 16'h0000;
               1:       d = 16'hFFFF;
               2:       d = 16'h8000;
               3:       d = 16'h7FFF;
               default: d = 16'($urandom);
            endcase
            s     = int'($urandom_range(0, 15));
            m     = int'($urandom_range(0, 3));
            tag_n = sent;
            mr    = model(d, s, 2'(m), 1'b1);
            drive(d, s, 2'(m), mr[WIDTH-1:0], mr[WIDTH]);
         end else begin
            bus.in_valid = 1'b0;
         end
         step();
         if (acc) sent++;
         cyc++;
      end
      check_value("rand_sent", 32'(sent), 32'd100);
      check_value("rand_empty", 32'(sb_q.size()), 32'd0);

      // Asynchronous reset with three operands in flight.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tag_n = 10 + i;
         drive(16'h7777 + 16'(i), 0, 2'b01, 16'h7777 + 16'(i), 1'b0);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();
      check_value("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      check_value("pre_rst_data",  32'(bus.out_data),  32'h7777);
      #2;
      rst_n = 1'b0;
      #1;
      check_value("arst_valid", 32'(bus.out_valid), 32'd0);
      check_value("arst_data",  32'(bus.out_data),  32'd0);
      check_value("arst_tag",   32'(bus.out_tag),   32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_value("post_rst_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      stale = 1'b0;
      repeat (6) begin
         if (bus.out_valid) stale = 1'b1;
         @(negedge clk);
      end
      check_value("post_rst_stale", 32'(stale), 32'd0);
      measure_latency("lat_post_rst", 16'h00F0, 4, 2'b01, 16'h000F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
